// File: rtl/lane_scroll_ctrl.sv
// Purpose : per-frame scroll scheduler; at vertical-blank start it steps every
//           lane's shadow offset through one shared adder, then commits all
//           lanes to the live offsets in a single cycle.
// Latency : vb_start at T -> UPDATE T+1..T+NUM_LANES, COMMIT T+NUM_LANES+1,
//           frame_tick and new live offsets visible at T+NUM_LANES+2.
// Backpressure: none; a vb_start seen while busy is dropped (no queueing),
//           and pause suppresses the whole frame's update when sampled at vb_start.
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   colPos, rowPos      : raster position from the VGA timing counters
//   pause               : skip this frame's update (sampled at vb_start only)
//   speed_cfg, dir_cfg  : per-lane speed (pixels/frame) and direction (1 = +)
//   row_offset          : registered live offset of the lane under rowPos
//   lane_offsets        : all live offsets, lane i at [i*OFFSET_W +: OFFSET_W]
//   frame_tick          : one-cycle pulse the cycle after commit
//   frame_count         : committed-frame counter (wraps)
//   busy                : high while in UPDATE or COMMIT

module lane_scroll_ctrl #(
    parameter int NUM_LANES   = 8,
    parameter int LANE_H      = 32,
    parameter int ACTIVE_ROWS = 480,
    parameter int OFFSET_W    = 11,
    parameter int SPEED_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [9:0]                    colPos,
    input  logic [9:0]                    rowPos,
    input  logic                          pause,
    input  logic [NUM_LANES*SPEED_W-1:0]  speed_cfg,
    input  logic [NUM_LANES-1:0]          dir_cfg,
    output logic [OFFSET_W-1:0]           row_offset,
    output logic [NUM_LANES*OFFSET_W-1:0] lane_offsets,
    output logic                          frame_tick,
    output logic [15:0]                   frame_count,
    output logic                          busy
);

    localparam int                IDX_W      = $clog2(NUM_LANES);
    localparam int                LANE_SHIFT = $clog2(LANE_H);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_LANES - 1);
    localparam logic [9:0]        VB_ROW     = 10'(ACTIVE_ROWS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_next_state;

    logic [IDX_W-1:0]      r_idx;
    logic                  r_vb_prev;
    logic [OFFSET_W-1:0]   r_shadow [NUM_LANES];
    logic [OFFSET_W-1:0]   r_live   [NUM_LANES];
    logic [OFFSET_W-1:0]   r_row_offset;
    logic                  r_frame_tick;
    logic [15:0]           r_frame_count;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                  w_vb_raw;
    logic                  w_vb_start;
    logic                  w_busy;
    logic                  w_start_frame;
    logic                  w_upd_en;
    logic                  w_commit_en;

    logic [OFFSET_W-1:0]   w_cur_shadow;
    logic [SPEED_W-1:0]    w_speed;
    logic [OFFSET_W-1:0]   w_speed_ext;
    logic                  w_dir;
    logic [OFFSET_W-1:0]   w_sum;

    logic [9:0]            w_lane;
    logic [OFFSET_W-1:0]   w_row_sel;

    // ------------------------------------------------------------------
    // Vertical-blank start: rising edge of the (ACTIVE_ROWS, 0) pixel, so a
    // raster parked on that pixel for several cycles starts only one frame.
    // ------------------------------------------------------------------
    assign w_vb_raw   = (rowPos == VB_ROW) && (colPos == 10'd0);
    assign w_vb_start = w_vb_raw && !r_vb_prev;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                // vb_start while paused leaves us in IDLE with nothing done
                if (w_vb_start && !pause) begin
                    w_next_state = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (r_idx == LAST_IDX) begin
                    w_next_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_busy        = 1'b0;
        w_start_frame = 1'b0;
        w_upd_en      = 1'b0;
        w_commit_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start_frame = w_vb_start && !pause;
            end
            S_UPDATE: begin
                w_busy   = 1'b1;
                w_upd_en = 1'b1;
            end
            S_COMMIT: begin
                w_busy      = 1'b1;
                w_commit_en = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shared adder/subtractor, steered by r_idx. Speed and direction are
    // taken live in the lane's own UPDATE cycle. Wrap is modulo 2^OFFSET_W
    // simply by truncation to the offset width.
    // ------------------------------------------------------------------
    assign w_cur_shadow = r_shadow[r_idx];
    assign w_speed      = speed_cfg[r_idx*SPEED_W +: SPEED_W];
    assign w_speed_ext  = OFFSET_W'(w_speed);
    assign w_dir        = dir_cfg[r_idx];
    assign w_sum        = w_dir ? (w_cur_shadow + w_speed_ext)
                                : (w_cur_shadow - w_speed_ext);

    // ------------------------------------------------------------------
    // Lane lookup for the row under the raster. Rows past the last lane
    // (lane index >= NUM_LANES) read as offset 0.
    // ------------------------------------------------------------------
    assign w_lane = rowPos >> LANE_SHIFT;

    always_comb begin
        w_row_sel = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_lane == 10'(i)) begin
                w_row_sel = r_live[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_vb_prev     <= 1'b0;
            r_row_offset  <= '0;
            r_frame_tick  <= 1'b0;
            r_frame_count <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_shadow[i] <= '0;
                r_live[i]   <= '0;
            end
        end else begin
            r_vb_prev    <= w_vb_raw;
            r_row_offset <= w_row_sel;
            // Tick lands the cycle after COMMIT, together with the new live
            // values; COMMIT lasts one cycle so the pulse can never repeat.
            r_frame_tick <= w_commit_en;

            if (w_start_frame) begin
                r_idx <= '0;
            end

            if (w_upd_en) begin
                r_shadow[r_idx] <= w_sum;
                r_idx           <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end

            if (w_commit_en) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_live[i] <= r_shadow[i];
                end
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane_out
            assign lane_offsets[g*OFFSET_W +: OFFSET_W] = r_live[g];
        end
    endgenerate

    assign row_offset  = r_row_offset;
    assign frame_tick  = r_frame_tick;
    assign frame_count = r_frame_count;
    assign busy        = w_busy;

endmodule

// File: tb/tb_lane_scroll_ctrl.sv
// Purpose : directed bench for lane_scroll_ctrl with hand-computed expectations.
// Latency : drives after posedge+1, samples at the same point (away from edges).
// Backpressure: n/a; every wait on the DUT is cycle-bounded.

module tb_lane_scroll_ctrl;

    localparam int NL = 8;
    localparam int OW = 11;
    localparam int SW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        colPos;
    logic [9:0]        rowPos;
    logic              pause;
    logic [NL*SW-1:0]  speed_cfg;
    logic [NL-1:0]     dir_cfg;
    logic [OW-1:0]     row_offset;
    logic [NL*OW-1:0]  lane_offsets;
    logic              frame_tick;
    logic [15:0]       frame_count;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;
    int tick_cnt = 0;
    int base;

    lane_scroll_ctrl #(
        .NUM_LANES  (NL),
        .LANE_H     (32),
        .ACTIVE_ROWS(480),
        .OFFSET_W   (OW),
        .SPEED_W    (SW)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .colPos      (colPos),
        .rowPos      (rowPos),
        .pause       (pause),
        .speed_cfg   (speed_cfg),
        .dir_cfg     (dir_cfg),
        .row_offset  (row_offset),
        .lane_offsets(lane_offsets),
        .frame_tick  (frame_tick),
        .frame_count (frame_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Count frame_tick cycles, sampled mid-cycle.
    always @(negedge clk) begin
        if (frame_tick) tick_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] lane(input int i);
        lane = lane_offsets[i*OW +: OW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Present the vb pixel for one cycle (cycle T); returns in cycle T+1.
    task automatic start_vb();
        rowPos = 10'd480;
        colPos = 10'd0;
        tick();
        rowPos = 10'd0;
        colPos = 10'd7;
    endtask

    // Wait (bounded) for frame_tick; returns in the cycle after the tick.
    task automatic wait_tick(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (frame_tick) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(seen), 32'd1);
        tick();
    endtask

    task automatic run_frame(input string tag);
        start_vb();
        wait_tick(tag);
    endtask

    task automatic set_speed(input int ln, input int spd, input logic d);
        speed_cfg[ln*SW +: SW] = SW'(spd);
        dir_cfg[ln]            = d;
    endtask

    initial begin
        reset     = 1'b1;
        colPos    = 10'd7;
        rowPos    = 10'd0;
        pause     = 1'b0;
        speed_cfg = '0;
        dir_cfg   = '0;
        do_reset();

        // ---------------- reset state ----------------
        chk("rst_offsets", 32'(lane_offsets == '0), 32'd1);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_row_offset", 32'(row_offset), 32'd0);

        // ---------------- basic frame timing: lane 0 speed 3, + ----------------
        set_speed(0, 3, 1'b1);
        start_vb();
        for (int k = 1; k <= 12; k++) begin
            chk($sformatf("busy_T+%0d", k), 32'(busy), 32'(k <= 9));
            chk($sformatf("tick_T+%0d", k), 32'(frame_tick), 32'(k == 10));
            if (k == 10) begin
                chk("t1_lane0", 32'(lane(0)), 32'd3);
                chk("t1_lane1", 32'(lane(1)), 32'd0);
                chk("t1_lane7", 32'(lane(7)), 32'd0);
                chk("t1_count", 32'(frame_count), 32'd1);
            end
            tick();
        end

        // ---------------- wrap-around ----------------
        do_reset();
        speed_cfg = '0;
        dir_cfg   = '0;
        set_speed(3, 5, 1'b0);
        run_frame("wrap_neg_frame");
        chk("wrap_neg_lane3", 32'(lane(3)), 32'd2043);
        chk("wrap_neg_lane0", 32'(lane(0)), 32'd0);

        set_speed(3, 0, 1'b0);
        set_speed(2, 15, 1'b1);
        for (int f = 0; f < 136; f++) run_frame("wrap_pos_frame");
        chk("wrap_pos_pre", 32'(lane(2)), 32'd2040);
        chk("wrap_lane3_hold", 32'(lane(3)), 32'd2043);
        run_frame("wrap_pos_frame");
        chk("wrap_pos_lane2", 32'(lane(2)), 32'd7);
        chk("wrap_count", 32'(frame_count), 32'd138);

        // ---------------- lookup: lane 2 = 100 ----------------
        do_reset();
        speed_cfg = '0;
        dir_cfg   = '0;
        set_speed(2, 10, 1'b1);
        for (int f = 0; f < 10; f++) run_frame("lookup_frame");
        chk("lookup_lane2", 32'(lane(2)), 32'd100);
        rowPos = 10'd0;
        tick();
        chk("lookup_row0", 32'(row_offset), 32'd0);
        rowPos = 10'd70;
        chk("lookup_lag", 32'(row_offset), 32'd0);
        tick();
        chk("lookup_row70", 32'(row_offset), 32'd100);
        rowPos = 10'd300;
        tick();
        chk("lookup_row300", 32'(row_offset), 32'd0);
        rowPos = 10'd0;

        // ---------------- pause at vb_start ----------------
        pause = 1'b1;
        base  = tick_cnt;
        start_vb();
        chk("pause_busy", 32'(busy), 32'd0);
        repeat (12) tick();
        chk("pause_no_tick", 32'(tick_cnt - base), 32'd0);
        chk("pause_lane2", 32'(lane(2)), 32'd100);
        chk("pause_count", 32'(frame_count), 32'd10);
        pause = 1'b0;

        // ---------------- pause raised mid-update ----------------
        start_vb();
        tick();
        tick();
        pause = 1'b1;
        wait_tick("midpause_frame");
        pause = 1'b0;
        chk("midpause_lane2", 32'(lane(2)), 32'd110);
        chk("midpause_count", 32'(frame_count), 32'd11);

        // ---------------- raster held on vb pixel ----------------
        base   = tick_cnt;
        rowPos = 10'd480;
        colPos = 10'd0;
        repeat (5) tick();
        rowPos = 10'd0;
        colPos = 10'd7;
        repeat (20) tick();
        chk("hold_ticks", 32'(tick_cnt - base), 32'd1);
        chk("hold_lane2", 32'(lane(2)), 32'd120);

        // ---------------- second vb_start while busy ----------------
        base = tick_cnt;
        start_vb();
        repeat (3) tick();
        rowPos = 10'd480;
        colPos = 10'd0;
        tick();
        rowPos = 10'd0;
        colPos = 10'd7;
        repeat (15) tick();
        chk("busy_vb_ticks", 32'(tick_cnt - base), 32'd1);
        chk("busy_vb_lane2", 32'(lane(2)), 32'd130);
        chk("busy_vb_count", 32'(frame_count), 32'd13);

        // ---------------- reset mid-update ----------------
        start_vb();
        rowPos = 10'd70;
        tick();
        chk("pre_rst_row", 32'(row_offset), 32'd130);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("midrst_offsets", 32'(lane_offsets == '0), 32'd1);
        chk("midrst_count", 32'(frame_count), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_tick", 32'(frame_tick), 32'd0);
        chk("midrst_row", 32'(row_offset), 32'd0);
        reset = 1'b0;
        rowPos = 10'd0;
        base = tick_cnt;
        repeat (15) tick();
        chk("midrst_no_tick", 32'(tick_cnt - base), 32'd0);
        chk("midrst_still0", 32'(lane(2)), 32'd0);
        run_frame("post_rst_frame");
        chk("post_rst_lane2", 32'(lane(2)), 32'd10);
        chk("post_rst_count", 32'(frame_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
